// File: rtl/reservation_station_pkg.sv
// Shared widths, op codes and entry layout for the ALU reservation station.
// Op codes match the EX unit's decode; OP_NOP=0 is the idle/reset encoding.
package reservation_station_pkg;
  localparam int RS_SIZE     = 16;
  localparam int RS_IDX_W    = 4;
  localparam int ROB_TAG_W   = 4;
  localparam int INST_TYPE_W = 6;
  localparam int DATA_W      = 32;

  localparam logic [INST_TYPE_W-1:0] OP_NOP  = 6'd0;
  localparam logic [INST_TYPE_W-1:0] OP_ADD  = 6'd1;
  localparam logic [INST_TYPE_W-1:0] OP_SUB  = 6'd2;
  localparam logic [INST_TYPE_W-1:0] OP_ADDI = 6'd3;
  localparam logic [INST_TYPE_W-1:0] OP_BEQ  = 6'd4;
  localparam logic [INST_TYPE_W-1:0] OP_JALR = 6'd5;

  typedef struct packed {
    logic                   busy;
    logic [INST_TYPE_W-1:0] ordertype;
    logic [DATA_W-1:0]      vj;
    logic [DATA_W-1:0]      vk;
    logic [ROB_TAG_W-1:0]   qj;
    logic [ROB_TAG_W-1:0]   qk;
    logic                   qj_busy;
    logic                   qk_busy;
    logic [DATA_W-1:0]      a;
    logic [DATA_W-1:0]      pc;
    logic [ROB_TAG_W-1:0]   rob_tag;
  } rs_entry_t;

  function automatic logic tag_hit(input logic vld, input logic [ROB_TAG_W-1:0] a,
                                   input logic [ROB_TAG_W-1:0] b);
    return vld && (a == b);
  endfunction
endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index-first priority encoder; combinational, no backpressure.
// idx_out is 0 when no request is set, so qualify it with vld_out.
module rs_prio_enc #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req_in,
  output logic         vld_out,
  output logic [W-1:0] idx_out
);
  always_comb begin
    idx_out = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_in[i]) idx_out = W'(i);
    end
  end

  assign vld_out = |req_in;
endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: issue -> dispatch to EX -> CDB broadcast, 3 edges, 1 op/cycle.
// rdy_in low freezes every register; issuer must hold issue_valid low while rs_full.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear_in,
  input  logic                   issue_valid,
  input  logic [INST_TYPE_W-1:0] issue_ordertype,
  input  logic [DATA_W-1:0]      issue_vj,
  input  logic [DATA_W-1:0]      issue_vk,
  input  logic [ROB_TAG_W-1:0]   issue_qj,
  input  logic [ROB_TAG_W-1:0]   issue_qk,
  input  logic                   issue_qj_busy,
  input  logic                   issue_qk_busy,
  input  logic [DATA_W-1:0]      issue_A,
  input  logic [DATA_W-1:0]      issue_pc,
  input  logic [ROB_TAG_W-1:0]   issue_rob_tag,
  output logic                   rs_full,
  input  logic                   cdb_alu_valid,
  input  logic [ROB_TAG_W-1:0]   cdb_alu_tag,
  input  logic [DATA_W-1:0]      cdb_alu_value,
  input  logic                   cdb_lsb_valid,
  input  logic [ROB_TAG_W-1:0]   cdb_lsb_tag,
  input  logic [DATA_W-1:0]      cdb_lsb_value,
  output logic [INST_TYPE_W-1:0] ex_ordertype,
  output logic [DATA_W-1:0]      ex_vj,
  output logic [DATA_W-1:0]      ex_vk,
  output logic [DATA_W-1:0]      ex_A,
  output logic [DATA_W-1:0]      ex_pc,
  input  logic [DATA_W-1:0]      ex_value_in,
  input  logic [DATA_W-1:0]      ex_jumppc_in,
  output logic                   cdb_out_valid,
  output logic [ROB_TAG_W-1:0]   cdb_out_tag,
  output logic [DATA_W-1:0]      cdb_out_value,
  output logic [DATA_W-1:0]      cdb_out_jumppc
);
  rs_entry_t              ent_q [RS_SIZE];
  rs_entry_t              ent_d [RS_SIZE];
  rs_entry_t              new_ent;
  logic [RS_SIZE-1:0]     busy_vec, ready_vec;
  logic                   free_vld, disp_vld;
  logic [RS_IDX_W-1:0]    free_idx, disp_idx;

  logic [INST_TYPE_W-1:0] ex_ordertype_q, ex_ordertype_d;
  logic [DATA_W-1:0]      ex_vj_q, ex_vj_d, ex_vk_q, ex_vk_d, ex_a_q, ex_a_d, ex_pc_q, ex_pc_d;
  logic [ROB_TAG_W-1:0]   ex_tag_q, ex_tag_d;
  logic                   ex_valid_q, ex_valid_d;
  logic                   cdb_out_valid_q, cdb_out_valid_d;
  logic [ROB_TAG_W-1:0]   cdb_out_tag_q, cdb_out_tag_d;
  logic [DATA_W-1:0]      cdb_out_value_q, cdb_out_value_d, cdb_out_jumppc_q, cdb_out_jumppc_d;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy;
    end
  end

  assign rs_full = &busy_vec;

  rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_enc (
    .req_in(~busy_vec), .vld_out(free_vld), .idx_out(free_idx));
  rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_disp_enc (
    .req_in(ready_vec), .vld_out(disp_vld), .idx_out(disp_idx));

  // New entry with same-cycle CDB bypass so an operand produced now is not missed.
  always_comb begin
    new_ent           = '0;
    new_ent.busy      = 1'b1;
    new_ent.ordertype = issue_ordertype;
    new_ent.vj        = issue_vj;
    new_ent.vk        = issue_vk;
    new_ent.qj        = issue_qj;
    new_ent.qk        = issue_qk;
    new_ent.qj_busy   = issue_qj_busy;
    new_ent.qk_busy   = issue_qk_busy;
    new_ent.a         = issue_A;
    new_ent.pc        = issue_pc;
    new_ent.rob_tag   = issue_rob_tag;
    if (issue_qj_busy && tag_hit(cdb_alu_valid, cdb_alu_tag, issue_qj)) begin
      new_ent.vj = cdb_alu_value; new_ent.qj_busy = 1'b0;
    end else if (issue_qj_busy && tag_hit(cdb_lsb_valid, cdb_lsb_tag, issue_qj)) begin
      new_ent.vj = cdb_lsb_value; new_ent.qj_busy = 1'b0;
    end
    if (issue_qk_busy && tag_hit(cdb_alu_valid, cdb_alu_tag, issue_qk)) begin
      new_ent.vk = cdb_alu_value; new_ent.qk_busy = 1'b0;
    end else if (issue_qk_busy && tag_hit(cdb_lsb_valid, cdb_lsb_tag, issue_qk)) begin
      new_ent.vk = cdb_lsb_value; new_ent.qk_busy = 1'b0;
    end
  end

  always_comb begin
    ent_d            = ent_q;
    ex_ordertype_d   = ex_ordertype_q;
    ex_vj_d          = ex_vj_q;
    ex_vk_d          = ex_vk_q;
    ex_a_d           = ex_a_q;
    ex_pc_d          = ex_pc_q;
    ex_tag_d         = ex_tag_q;
    ex_valid_d       = ex_valid_q;
    cdb_out_valid_d  = cdb_out_valid_q;
    cdb_out_tag_d    = cdb_out_tag_q;
    cdb_out_value_d  = cdb_out_value_q;
    cdb_out_jumppc_d = cdb_out_jumppc_q;
    if (rdy_in) begin
      if (clear_in) begin
        for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
        ex_valid_d      = 1'b0;
        cdb_out_valid_d = 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent_q[i].busy && ent_q[i].qj_busy) begin
            if (tag_hit(cdb_alu_valid, cdb_alu_tag, ent_q[i].qj)) begin
              ent_d[i].vj = cdb_alu_value; ent_d[i].qj_busy = 1'b0;
            end else if (tag_hit(cdb_lsb_valid, cdb_lsb_tag, ent_q[i].qj)) begin
              ent_d[i].vj = cdb_lsb_value; ent_d[i].qj_busy = 1'b0;
            end
          end
          if (ent_q[i].busy && ent_q[i].qk_busy) begin
            if (tag_hit(cdb_alu_valid, cdb_alu_tag, ent_q[i].qk)) begin
              ent_d[i].vk = cdb_alu_value; ent_d[i].qk_busy = 1'b0;
            end else if (tag_hit(cdb_lsb_valid, cdb_lsb_tag, ent_q[i].qk)) begin
              ent_d[i].vk = cdb_lsb_value; ent_d[i].qk_busy = 1'b0;
            end
          end
        end
        ex_valid_d = disp_vld;
        if (disp_vld) begin
          ex_ordertype_d       = ent_q[disp_idx].ordertype;
          ex_vj_d              = ent_q[disp_idx].vj;
          ex_vk_d              = ent_q[disp_idx].vk;
          ex_a_d               = ent_q[disp_idx].a;
          ex_pc_d              = ent_q[disp_idx].pc;
          ex_tag_d             = ent_q[disp_idx].rob_tag;
          ent_d[disp_idx].busy = 1'b0;
        end
        // free_idx comes from registered busy, so a slot freed by this dispatch is not reused until next cycle.
        if (issue_valid && free_vld) ent_d[free_idx] = new_ent;
        cdb_out_valid_d  = ex_valid_q;
        cdb_out_tag_d    = ex_tag_q;
        cdb_out_value_d  = ex_value_in;
        cdb_out_jumppc_d = ex_jumppc_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      ex_ordertype_q   <= '0;
      ex_vj_q          <= '0;
      ex_vk_q          <= '0;
      ex_a_q           <= '0;
      ex_pc_q          <= '0;
      ex_tag_q         <= '0;
      ex_valid_q       <= 1'b0;
      cdb_out_valid_q  <= 1'b0;
      cdb_out_tag_q    <= '0;
      cdb_out_value_q  <= '0;
      cdb_out_jumppc_q <= '0;
    end else begin
      ent_q            <= ent_d;
      ex_ordertype_q   <= ex_ordertype_d;
      ex_vj_q          <= ex_vj_d;
      ex_vk_q          <= ex_vk_d;
      ex_a_q           <= ex_a_d;
      ex_pc_q          <= ex_pc_d;
      ex_tag_q         <= ex_tag_d;
      ex_valid_q       <= ex_valid_d;
      cdb_out_valid_q  <= cdb_out_valid_d;
      cdb_out_tag_q    <= cdb_out_tag_d;
      cdb_out_value_q  <= cdb_out_value_d;
      cdb_out_jumppc_q <= cdb_out_jumppc_d;
    end
  end

  assign ex_ordertype   = ex_ordertype_q;
  assign ex_vj          = ex_vj_q;
  assign ex_vk          = ex_vk_q;
  assign ex_A           = ex_a_q;
  assign ex_pc          = ex_pc_q;
  assign cdb_out_valid  = cdb_out_valid_q;
  assign cdb_out_tag    = cdb_out_tag_q;
  assign cdb_out_value  = cdb_out_value_q;
  assign cdb_out_jumppc = cdb_out_jumppc_q;
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: behavioural EX unit, scoreboard on the ALU CDB output,
// plus directed checks on latency, wakeup, bypass, full, ordering, flush and stall.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic                   clk_in = 1'b0;
  logic                   rst_in = 1'b1;
  logic                   rdy_in = 1'b1;
  logic                   clear_in = 1'b0;
  logic                   issue_valid = 1'b0;
  logic [INST_TYPE_W-1:0] issue_ordertype = '0;
  logic [DATA_W-1:0]      issue_vj = '0, issue_vk = '0, issue_A = '0, issue_pc = '0;
  logic [ROB_TAG_W-1:0]   issue_qj = '0, issue_qk = '0, issue_rob_tag = '0;
  logic                   issue_qj_busy = 1'b0, issue_qk_busy = 1'b0;
  logic                   rs_full;
  logic                   cdb_alu_valid = 1'b0, cdb_lsb_valid = 1'b0;
  logic [ROB_TAG_W-1:0]   cdb_alu_tag = '0, cdb_lsb_tag = '0;
  logic [DATA_W-1:0]      cdb_alu_value = '0, cdb_lsb_value = '0;
  logic [INST_TYPE_W-1:0] ex_ordertype;
  logic [DATA_W-1:0]      ex_vj, ex_vk, ex_A, ex_pc;
  logic [DATA_W-1:0]      ex_value_in, ex_jumppc_in;
  logic                   cdb_out_valid;
  logic [ROB_TAG_W-1:0]   cdb_out_tag;
  logic [DATA_W-1:0]      cdb_out_value, cdb_out_jumppc;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] tag;
    logic [DATA_W-1:0]    val;
    logic [DATA_W-1:0]    jpc;
  } exp_t;
  exp_t sb [$];

  int checks = 0;
  int errors = 0;
  logic prev_rdy = 1'b0;

  reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_valid(issue_valid), .issue_ordertype(issue_ordertype),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_A(issue_A), .issue_pc(issue_pc), .issue_rob_tag(issue_rob_tag),
    .rs_full(rs_full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_value(cdb_alu_value),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_value(cdb_lsb_value),
    .ex_ordertype(ex_ordertype), .ex_vj(ex_vj), .ex_vk(ex_vk), .ex_A(ex_A), .ex_pc(ex_pc),
    .ex_value_in(ex_value_in), .ex_jumppc_in(ex_jumppc_in),
    .cdb_out_valid(cdb_out_valid), .cdb_out_tag(cdb_out_tag),
    .cdb_out_value(cdb_out_value), .cdb_out_jumppc(cdb_out_jumppc)
  );

  always #5 clk_in = ~clk_in;

  // Stand-in for the combinational EX unit.
  always_comb begin
    ex_value_in  = '0;
    ex_jumppc_in = '0;
    case (ex_ordertype)
      OP_ADD:  ex_value_in = ex_vj + ex_vk;
      OP_SUB:  ex_value_in = ex_vj - ex_vk;
      OP_ADDI: ex_value_in = ex_vj + ex_A;
      OP_BEQ:  ex_value_in = {31'd0, ex_vj == ex_vk};
      OP_JALR: begin
        ex_value_in  = ex_pc + 32'd4;
        ex_jumppc_in = (ex_vj + ex_A) & ~32'd1;
      end
      default: ex_value_in = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [INST_TYPE_W-1:0] ot, input logic [DATA_W-1:0] vj,
                       input logic [DATA_W-1:0] vk, input logic [ROB_TAG_W-1:0] qj, input logic qjb,
                       input logic [ROB_TAG_W-1:0] qk, input logic qkb, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] pc, input logic [ROB_TAG_W-1:0] tag);
    issue_valid = 1'b1; issue_ordertype = ot; issue_vj = vj; issue_vk = vk;
    issue_qj = qj; issue_qj_busy = qjb; issue_qk = qk; issue_qk_busy = qkb;
    issue_A = a; issue_pc = pc; issue_rob_tag = tag;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic push(input logic [ROB_TAG_W-1:0] tag, input logic [DATA_W-1:0] val,
                      input logic [DATA_W-1:0] jpc);
    exp_t e;
    e.tag = tag; e.val = val; e.jpc = jpc;
    sb.push_back(e);
  endtask

  task automatic cdb_idle();
    cdb_alu_valid = 1'b0;
    cdb_lsb_valid = 1'b0;
  endtask

  // Scoreboard: only count a broadcast produced by an edge where the RS was enabled.
  always @(negedge clk_in) begin
    if (!rst_in && prev_rdy && cdb_out_valid) begin
      if (sb.size() == 0) begin
        chk("cdb_unexpected", {63'd0, cdb_out_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("cdb_tag", {60'd0, cdb_out_tag}, {60'd0, e.tag});
        chk("cdb_value", {32'd0, cdb_out_value}, {32'd0, e.val});
        chk("cdb_jumppc", {32'd0, cdb_out_jumppc}, {32'd0, e.jpc});
      end
    end
    if (!rst_in && rdy_in && !clear_in && issue_valid)
      chk("issue_not_full", {63'd0, rs_full}, 64'd0);
    prev_rdy = rdy_in && !clear_in && !rst_in;
  end

  initial begin
    repeat (3) tick();
    rst_in = 1'b0;
    chk("rst_rs_full", {63'd0, rs_full}, 64'd0);
    chk("rst_cdb_valid", {63'd0, cdb_out_valid}, 64'd0);
    chk("rst_ex_ordertype", {58'd0, ex_ordertype}, 64'd0);
    chk("rst_ex_vj", {32'd0, ex_vj}, 64'd0);
    chk("rst_cdb_value", {32'd0, cdb_out_value}, 64'd0);

    // 1: ready ADD, 3-edge latency
    push(4'd3, 32'd12, 32'd0);
    issue(OP_ADD, 32'd5, 32'd7, 4'd0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd3);
    tick();
    chk("t1_ex_ordertype", {58'd0, ex_ordertype}, {58'd0, OP_ADD});
    chk("t1_ex_vj", {32'd0, ex_vj}, 64'd5);
    chk("t1_ex_vk", {32'd0, ex_vk}, 64'd7);
    tick();
    chk("t1_cdb_valid", {63'd0, cdb_out_valid}, 64'd1);
    chk("t1_cdb_tag", {60'd0, cdb_out_tag}, 64'd3);
    chk("t1_cdb_value", {32'd0, cdb_out_value}, 64'd12);

    // branch compare result and JALR jump target, back to back
    push(4'd1, 32'd1, 32'd0);
    push(4'd2, 32'd44, 32'd108);
    issue(OP_BEQ, 32'd4, 32'd4, 4'd0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd1);
    issue(OP_JALR, 32'd100, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'd8, 32'd40, 4'd2);
    repeat (4) tick();

    // 2: SUB waiting on tag 2, woken by the load/store CDB
    issue(OP_SUB, 32'd0, 32'd3, 4'd2, 1'b1, 4'd0, 1'b0, 32'd0, 32'd0, 4'd5);
    repeat (4) tick();
    chk("t2_no_early_dispatch", {58'd0, ex_ordertype}, {58'd0, OP_JALR});
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 4'd2; cdb_lsb_value = 32'd20;
    push(4'd5, 32'd17, 32'd0);
    tick();
    cdb_idle();
    chk("t2_not_same_edge", {58'd0, ex_ordertype}, {58'd0, OP_JALR});
    tick();
    chk("t2_ex_ordertype", {58'd0, ex_ordertype}, {58'd0, OP_SUB});
    chk("t2_ex_vj", {32'd0, ex_vj}, 64'd20);
    repeat (3) tick();

    // 3: issue-time bypass from the ALU CDB
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd6; cdb_alu_value = 32'd9;
    push(4'd7, 32'd10, 32'd0);
    issue(OP_ADD, 32'd1, 32'd0, 4'd0, 1'b0, 4'd6, 1'b1, 32'd0, 32'd0, 4'd7);
    cdb_idle();
    tick();
    chk("t3_ex_ordertype", {58'd0, ex_ordertype}, {58'd0, OP_ADD});
    chk("t3_ex_vk", {32'd0, ex_vk}, 64'd9);
    repeat (3) tick();

    // 4: fill all entries, wake only entry 5
    for (int i = 0; i < RS_SIZE; i++) begin
      if (i == RS_SIZE - 1) chk("t4_not_full_before_last", {63'd0, rs_full}, 64'd0);
      issue(OP_ADDI, 32'd0, 32'd0, (i == 5) ? 4'd10 : 4'd11, 1'b1, 4'd0, 1'b0,
            32'(i), 32'd0, 4'(i));
    end
    chk("t4_full", {63'd0, rs_full}, 64'd1);
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 4'd10; cdb_lsb_value = 32'd100;
    push(4'd5, 32'd105, 32'd0);
    tick();
    cdb_idle();
    chk("t4_full_at_wake", {63'd0, rs_full}, 64'd1);
    tick();
    chk("t4_not_full_after_dispatch", {63'd0, rs_full}, 64'd0);
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd11; cdb_alu_value = 32'd50;
    for (int i = 0; i < RS_SIZE; i++) if (i != 5) push(4'(i), 32'(50 + i), 32'd0);
    tick();
    cdb_idle();
    repeat (20) tick();

    // 5: entries 1, 4, 9 become ready together
    for (int i = 0; i < 10; i++)
      issue(OP_ADDI, 32'd0, 32'd0, (i == 1 || i == 4 || i == 9) ? 4'd13 : 4'd12, 1'b1,
            4'd0, 1'b0, 32'(i), 32'd0, 4'(i));
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd13; cdb_alu_value = 32'd200;
    push(4'd1, 32'd201, 32'd0);
    push(4'd4, 32'd204, 32'd0);
    push(4'd9, 32'd209, 32'd0);
    tick();
    cdb_idle();
    tick();
    tick();
    chk("t5_first_valid", {63'd0, cdb_out_valid}, 64'd1);
    chk("t5_first_tag", {60'd0, cdb_out_tag}, 64'd1);
    tick();
    chk("t5_second_valid", {63'd0, cdb_out_valid}, 64'd1);
    chk("t5_second_tag", {60'd0, cdb_out_tag}, 64'd4);
    tick();
    chk("t5_third_valid", {63'd0, cdb_out_valid}, 64'd1);
    chk("t5_third_tag", {60'd0, cdb_out_tag}, 64'd9);
    tick();
    chk("t5_burst_end", {63'd0, cdb_out_valid}, 64'd0);
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 4'd12; cdb_lsb_value = 32'd300;
    for (int i = 0; i < 10; i++)
      if (i != 1 && i != 4 && i != 9) push(4'(i), 32'(300 + i), 32'd0);
    tick();
    cdb_idle();
    repeat (12) tick();

    // 6: flush with an op in EX, then stall
    for (int i = 0; i < RS_SIZE; i++)
      issue(OP_ADDI, 32'd0, 32'd0, (i == 0) ? 4'd14 : 4'd15, 1'b1, 4'd0, 1'b0,
            32'(i), 32'd0, 4'(i));
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd14; cdb_alu_value = 32'd0;
    tick();
    cdb_idle();
    tick();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    chk("t6_clear_no_cdb", {63'd0, cdb_out_valid}, 64'd0);
    chk("t6_clear_not_full", {63'd0, rs_full}, 64'd0);
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd15; cdb_alu_value = 32'd0;
    tick();
    cdb_idle();
    chk("t6_clear_still_no_cdb", {63'd0, cdb_out_valid}, 64'd0);
    repeat (4) tick();
    for (int i = 0; i < RS_SIZE; i++) begin
      if (i == RS_SIZE - 1) chk("t6_refill_not_full", {63'd0, rs_full}, 64'd0);
      issue(OP_ADDI, 32'd0, 32'd0, (i == 0) ? 4'd1 : 4'd2, 1'b1, 4'd0, 1'b0,
            32'(i), 32'd0, 4'(i));
    end
    chk("t6_refill_full", {63'd0, rs_full}, 64'd1);
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 4'd1; cdb_lsb_value = 32'd7;
    push(4'd0, 32'd7, 32'd0);
    tick();
    cdb_idle();
    tick();
    tick();
    chk("t6_pre_stall_valid", {63'd0, cdb_out_valid}, 64'd1);
    rdy_in = 1'b0;
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd2; cdb_alu_value = 32'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_stall_cdb_valid", {63'd0, cdb_out_valid}, 64'd1);
      chk("t6_stall_cdb_value", {32'd0, cdb_out_value}, 64'd7);
      chk("t6_stall_ex_ordertype", {58'd0, ex_ordertype}, {58'd0, OP_ADDI});
      chk("t6_stall_rs_full", {63'd0, rs_full}, 64'd0);
    end
    cdb_idle();
    rdy_in = 1'b1;
    tick();
    chk("t6_after_stall_valid", {63'd0, cdb_out_valid}, 64'd0);
    repeat (4) tick();
    chk("t6_stall_wake_ignored", {63'd0, cdb_out_valid}, 64'd0);
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd2; cdb_alu_value = 32'd1000;
    for (int i = 1; i < RS_SIZE; i++) push(4'(i), 32'(1000 + i), 32'd0);
    tick();
    cdb_idle();
    repeat (22) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
